// File: rtl/arb_2to1_avlstrm.sv
// Two-input Avalon-ST packet arbiter with round-robin grant and packet locking.
// Optional packet/drop statistics counters are built when ARB_STATS_EN is defined.
module arb_2to1_avlstrm #(
    parameter int DATA_W  = 512,
    parameter int EMPTY_W = 6
) (
    input  logic               Clk,
    input  logic               Rst_n,

    input  logic [DATA_W-1:0]  in0_data,
    input  logic               in0_valid,
    input  logic               in0_sop,
    input  logic               in0_eop,
    input  logic [EMPTY_W-1:0] in0_empty,
    output logic               in0_ready,

    input  logic [DATA_W-1:0]  in1_data,
    input  logic               in1_valid,
    input  logic               in1_sop,
    input  logic               in1_eop,
    input  logic [EMPTY_W-1:0] in1_empty,
    output logic               in1_ready,

    output logic [DATA_W-1:0]  out_data,
    output logic               out_valid,
    output logic               out_sop,
    output logic               out_eop,
    output logic [EMPTY_W-1:0] out_empty,
    input  logic               out_ready,
    input  logic               out_almost_full,
    output logic               out_src,

    output logic [31:0]        stats_in0_pkt,
    output logic [31:0]        stats_in1_pkt,
    output logic [31:0]        stats_out_pkt,
    output logic [31:0]        stats_drop
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        LOCK0 = 2'd1,
        LOCK1 = 2'd2
    } state_t;

    state_t state_q, state_d;
    logic   rr_q, rr_d;
    logic   src_q, src_d;

    logic   req0, req1;
    logic   drop0, drop1;
    logic   sel, sel_valid, sel_eop, accept;

    always_comb begin
        state_d   = state_q;
        rr_d      = rr_q;
        src_d     = src_q;
        req0      = 1'b0;
        req1      = 1'b0;
        drop0     = 1'b0;
        drop1     = 1'b0;
        sel       = src_q;
        sel_valid = 1'b0;

        case (state_q)
            IDLE: begin
                // A mid-packet beat seen while idle has no owner; swallow it.
                drop0     = in0_valid & ~in0_sop;
                drop1     = in1_valid & ~in1_sop;
                req0      = in0_valid & in0_sop & ~out_almost_full;
                req1      = in1_valid & in1_sop & ~out_almost_full;
                sel       = (req0 & req1) ? rr_q : req1;
                sel_valid = req0 | req1;
            end
            LOCK0: begin
                sel       = 1'b0;
                sel_valid = in0_valid;
            end
            LOCK1: begin
                sel       = 1'b1;
                sel_valid = in1_valid;
            end
            default: state_d = IDLE;
        endcase

        if (Rst_n) begin
            drop0     = 1'b0;
            drop1     = 1'b0;
            sel_valid = 1'b0;
        end

        sel_eop = sel ? in1_eop : in0_eop;
        accept  = sel_valid & out_ready;

        in0_ready = drop0 | (out_ready & ~Rst_n & ((sel_valid & ~sel) | (state_q == LOCK0)));
        in1_ready = drop1 | (out_ready & ~Rst_n & ((sel_valid &  sel) | (state_q == LOCK1)));

        if (sel_valid) begin
            src_d = sel;
        end

        if (accept) begin
            if (sel_eop) begin
                state_d = IDLE;
                rr_d    = ~sel;
            end else if (state_q == IDLE) begin
                state_d = sel ? LOCK1 : LOCK0;
            end
        end
    end

    always_ff @(posedge Clk) begin
        if (Rst_n) begin
            state_q <= IDLE;
            rr_q    <= 1'b0;
            src_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            rr_q    <= rr_d;
            src_q   <= src_d;
        end
    end

    assign out_valid = sel_valid;
    assign out_src   = sel_valid ? sel : src_q;
    assign out_data  = sel ? in1_data  : in0_data;
    assign out_sop   = sel ? in1_sop   : in0_sop;
    assign out_eop   = sel_eop;
    assign out_empty = sel ? in1_empty : in0_empty;

`ifdef ARB_STATS_EN
    logic [31:0] in0_pkt_q, in0_pkt_d;
    logic [31:0] in1_pkt_q, in1_pkt_d;
    logic [31:0] out_pkt_q, out_pkt_d;
    logic [31:0] drop_q,    drop_d;

    always_comb begin
        in0_pkt_d = in0_pkt_q + {31'd0, accept & ~sel & sel_eop};
        in1_pkt_d = in1_pkt_q + {31'd0, accept &  sel & sel_eop};
        out_pkt_d = out_pkt_q + {31'd0, accept & sel_eop};
        drop_d    = drop_q + {31'd0, drop0} + {31'd0, drop1};
    end

    always_ff @(posedge Clk) begin
        if (Rst_n) begin
            in0_pkt_q <= '0;
            in1_pkt_q <= '0;
            out_pkt_q <= '0;
            drop_q    <= '0;
        end else begin
            in0_pkt_q <= in0_pkt_d;
            in1_pkt_q <= in1_pkt_d;
            out_pkt_q <= out_pkt_d;
            drop_q    <= drop_d;
        end
    end

    assign stats_in0_pkt = in0_pkt_q;
    assign stats_in1_pkt = in1_pkt_q;
    assign stats_out_pkt = out_pkt_q;
    assign stats_drop    = drop_q;
`else
    assign stats_in0_pkt = '0;
    assign stats_in1_pkt = '0;
    assign stats_out_pkt = '0;
    assign stats_drop    = '0;
`endif

endmodule
